// File: rtl/td4_fetch_unit_if.sv
// Bus bundle between the TD4 fetch unit and its controller/decoder side.
// The slave modport is the fetch unit; the master modport drives program load and run control.
interface td4_fetch_unit_if;
  logic       progWe_i;
  logic [3:0] progAddr_i;
  logic [7:0] progData_i;
  logic       run_i;
  logic       step_i;
  logic       ldPc_i;
  logic       carryIn_i;
  logic [3:0] opcode_o;
  logic [3:0] imm_o;
  logic       cflg_o;
  logic [3:0] pc_o;
  logic       exec_o;
  logic       halted_o;

  modport slave (
    input  progWe_i, progAddr_i, progData_i, run_i, step_i, ldPc_i, carryIn_i,
    output opcode_o, imm_o, cflg_o, pc_o, exec_o, halted_o
  );

  modport master (
    output progWe_i, progAddr_i, progData_i, run_i, step_i, ldPc_i, carryIn_i,
    input  opcode_o, imm_o, cflg_o, pc_o, exec_o, halted_o
  );
endinterface

// File: rtl/td4_fetch_unit.sv
// TD4 fetch unit: program memory, PC, instruction register and carry flag,
// sequencing every instruction through a FETCH/EXEC cycle pair.
module td4_fetch_unit #(
  parameter logic [3:0] RESET_PC      = 4'h0,
  parameter bit         MEM_INIT_ZERO = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  td4_fetch_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [7:0] MEM_INIT_VAL = MEM_INIT_ZERO ? 8'h00 : 8'hxx;

  // Power-up contents only; reset deliberately leaves the program intact.
  logic [7:0] mem_q [16] = '{default: MEM_INIT_VAL};

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       cflg_q, cflg_d;

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && bus.progWe_i) begin
      mem_q[bus.progAddr_i] <= bus.progData_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      cflg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cflg_q  <= cflg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cflg_d  = cflg_q;
    unique case (state_q)
      IDLE: begin
        if (bus.run_i || bus.step_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = EXEC;
      end
      EXEC: begin
        // A dropped RUN still lets this instruction retire before halting.
        pc_d    = bus.ldPc_i ? ir_q[3:0] : pc_q + 4'd1;
        cflg_d  = bus.carryIn_i;
        state_d = bus.run_i ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.opcode_o = ir_q[7:4];
  assign bus.imm_o    = ir_q[3:0];
  assign bus.cflg_o   = cflg_q;
  assign bus.pc_o     = pc_q;
  assign bus.exec_o   = (state_q == EXEC);
  assign bus.halted_o = (state_q == IDLE);

endmodule

// File: tb/tb_td4_fetch_unit.sv
// Directed testbench for td4_fetch_unit: load/step, jump, wrap/run, carry,
// halt with write lockout, and reset mid-run.
module tb_td4_fetch_unit;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  td4_fetch_unit_if bus ();

  td4_fetch_unit #(
    .RESET_PC      (4'h0),
    .MEM_INIT_ZERO (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    bus.progWe_i   = 1'b1;
    bus.progAddr_i = addr;
    bus.progData_i = data;
    tick();
    bus.progWe_i   = 1'b0;
  endtask

  // One STEP instruction; checks the EXEC-cycle IR and the resulting PC.
  task automatic stepInstr(input string tag, input logic ldPc, input logic carry,
                           input logic [3:0] expOp, input logic [3:0] expImm,
                           input logic [3:0] expPc);
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    checkOutput({tag, "_fetch_exec"}, {7'd0, bus.exec_o}, 8'd0);
    tick();
    bus.ldPc_i    = ldPc;
    bus.carryIn_i = carry;
    checkOutput({tag, "_exec"},   {7'd0, bus.exec_o}, 8'd1);
    checkOutput({tag, "_opcode"}, {4'd0, bus.opcode_o}, {4'd0, expOp});
    checkOutput({tag, "_imm"},    {4'd0, bus.imm_o}, {4'd0, expImm});
    tick();
    bus.ldPc_i    = 1'b0;
    bus.carryIn_i = 1'b0;
    checkOutput({tag, "_halted"}, {7'd0, bus.halted_o}, 8'd1);
    checkOutput({tag, "_pc"},     {4'd0, bus.pc_o}, {4'd0, expPc});
  endtask

  logic [3:0] wrapPc   [8] = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd0, 4'd0, 4'd1, 4'd1};
  logic       wrapExec [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    testsRun       = 0;
    testsFailed    = 0;
    rst            = 1'b1;
    bus.progWe_i   = 1'b0;
    bus.progAddr_i = 4'd0;
    bus.progData_i = 8'd0;
    bus.run_i      = 1'b0;
    bus.step_i     = 1'b0;
    bus.ldPc_i     = 1'b0;
    bus.carryIn_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_pc",     {4'd0, bus.pc_o}, 8'd0);
    checkOutput("rst_opcode", {4'd0, bus.opcode_o}, 8'd0);
    checkOutput("rst_cflg",   {7'd0, bus.cflg_o}, 8'd0);
    checkOutput("rst_exec",   {7'd0, bus.exec_o}, 8'd0);
    checkOutput("rst_halted", {7'd0, bus.halted_o}, 8'd1);

    applyStimulus(4'd0,  8'h35);
    applyStimulus(4'd1,  8'hB7);
    applyStimulus(4'd2,  8'hF9);
    applyStimulus(4'd3,  8'hFE);
    applyStimulus(4'd9,  8'hF2);
    applyStimulus(4'd14, 8'h1E);
    applyStimulus(4'd15, 8'h2F);

    stepInstr("step0", 1'b0, 1'b0, 4'h3, 4'h5, 4'd1);
    stepInstr("step1", 1'b0, 1'b0, 4'hB, 4'h7, 4'd2);
    stepInstr("jump",  1'b1, 1'b0, 4'hF, 4'h9, 4'd9);
    stepInstr("jback", 1'b1, 1'b0, 4'hF, 4'h2, 4'd2);
    stepInstr("nojmp", 1'b0, 1'b0, 4'hF, 4'h9, 4'd3);
    stepInstr("to14",  1'b1, 1'b0, 4'hF, 4'hE, 4'd14);

    bus.run_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("wrap_pc%0d", i),   {4'd0, bus.pc_o}, {4'd0, wrapPc[i]});
      checkOutput($sformatf("wrap_exec%0d", i), {7'd0, bus.exec_o}, {7'd0, wrapExec[i]});
    end
    bus.run_i = 1'b0;
    tick();
    checkOutput("wrap_halted", {7'd0, bus.halted_o}, 8'd1);
    checkOutput("wrap_pc_end", {4'd0, bus.pc_o}, 8'd2);

    stepInstr("carry1", 1'b0, 1'b1, 4'hF, 4'h9, 4'd3);
    checkOutput("cflg_set", {7'd0, bus.cflg_o}, 8'd1);
    bus.step_i = 1'b1;
    tick();
    bus.step_i = 1'b0;
    checkOutput("cflg_fetch", {7'd0, bus.cflg_o}, 8'd1);
    tick();
    checkOutput("cflg_exec", {7'd0, bus.cflg_o}, 8'd1);
    tick();
    checkOutput("cflg_clear", {7'd0, bus.cflg_o}, 8'd0);
    checkOutput("carry_pc",   {4'd0, bus.pc_o}, 8'd4);

    bus.run_i = 1'b1;
    tick();
    checkOutput("halt_fetch", {7'd0, bus.exec_o}, 8'd0);
    bus.run_i      = 1'b0;
    bus.progWe_i   = 1'b1;
    bus.progAddr_i = 4'd0;
    bus.progData_i = 8'hFF;
    tick();
    checkOutput("halt_exec",   {7'd0, bus.exec_o}, 8'd1);
    checkOutput("halt_opcode", {4'd0, bus.opcode_o}, 8'd0);
    tick();
    bus.progWe_i = 1'b0;
    checkOutput("halt_halted", {7'd0, bus.halted_o}, 8'd1);
    checkOutput("halt_pc",     {4'd0, bus.pc_o}, 8'd5);

    bus.run_i = 1'b1;
    tick();
    tick();
    checkOutput("rstrun_exec", {7'd0, bus.exec_o}, 8'd1);
    bus.carryIn_i = 1'b1;
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.run_i     = 1'b0;
    bus.carryIn_i = 1'b0;
    checkOutput("rstrun_pc",     {4'd0, bus.pc_o}, 8'd0);
    checkOutput("rstrun_opcode", {4'd0, bus.opcode_o}, 8'd0);
    checkOutput("rstrun_imm",    {4'd0, bus.imm_o}, 8'd0);
    checkOutput("rstrun_cflg",   {7'd0, bus.cflg_o}, 8'd0);
    checkOutput("rstrun_exec0",  {7'd0, bus.exec_o}, 8'd0);
    checkOutput("rstrun_halted", {7'd0, bus.halted_o}, 8'd1);

    stepInstr("retain0", 1'b0, 1'b0, 4'h3, 4'h5, 4'd1);
    stepInstr("retain1", 1'b0, 1'b0, 4'hB, 4'h7, 4'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
